// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage RV32I core.
//
// Purpose:
//   - Detects load-use hazards between Decode and Execute and holds F/D for
//     LOAD_STALL_CYCLES bubble cycles (for multi-cycle data memory reads).
//   - Flushes D and E on a taken branch/jump resolved in Execute. The branch
//     wins over any stall because the Decode instruction is wrong-path.
//   - Generates Execute-stage forwarding selects (M has priority over W).
//   - Keeps a saturating count of cycles with stallF asserted.
//
// Ports:
//   clk, rst_n                   core clock (rising edge), async active-low reset
//   rs1_addr_D/rs2_addr_D        Decode source register addresses
//   use_rs1_D/use_rs2_D          Decode instruction reads rs1/rs2
//   rd_E, sel_wb_E               Execute destination and writeback select
//   rs1_addr_E/rs2_addr_E        Execute source register addresses
//   branch_taken_E               Execute resolved a taken branch or jump
//   rd_M, reg_write_M            Memory-stage destination / write enable
//   rd_W, reg_write_W            Writeback destination / write enable
//   perf_clr                     synchronous clear of stall_cycles
//   stallF, stallD               hold PC / hold F/D register
//   flushD, flushE               bubble F/D / bubble D/E register
//   fwd_a_E, fwd_b_E             operand selects: 00 regfile, 10 from M, 01 from W
//   stall_cycles                 saturating count of stallF cycles
//   dbg_state                    current FSM state (0 IDLE, 1 STALL)
module hazard_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int SEL_WB_W          = 2,
  parameter int WB_SEL_LOAD       = 0,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr_D,
  input  logic [REG_ADDR_W-1:0] rs2_addr_D,
  input  logic                  use_rs1_D,
  input  logic                  use_rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic [SEL_WB_W-1:0]   sel_wb_E,
  input  logic [REG_ADDR_W-1:0] rs1_addr_E,
  input  logic [REG_ADDR_W-1:0] rs2_addr_E,
  input  logic                  branch_taken_E,
  input  logic [REG_ADDR_W-1:0] rd_M,
  input  logic                  reg_write_M,
  input  logic [REG_ADDR_W-1:0] rd_W,
  input  logic                  reg_write_W,
  input  logic                  perf_clr,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE,
  output logic [1:0]            fwd_a_E,
  output logic [1:0]            fwd_b_E,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  dbg_state
);

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15) begin : g_bad_stall_cycles
    $error("hazard_ctrl: LOAD_STALL_CYCLES must be in 1..15");
  end

  localparam logic [SEL_WB_W-1:0] LP_SEL_LOAD  = SEL_WB_W'(WB_SEL_LOAD);
  // Bubbles still owed after the first one, which is issued from IDLE.
  localparam logic [3:0]          LP_EXTRA_BUB = 4'(LOAD_STALL_CYCLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_bub_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_haz;
  logic       w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Load in E whose destination is a source the D instruction actually reads.
  assign w_haz = (sel_wb_E == LP_SEL_LOAD) && (rd_E != '0) &&
                 ((use_rs1_D && (rs1_addr_D == rd_E)) ||
                  (use_rs2_D && (rs2_addr_D == rd_E)));

  // In STALL the bubble run continues regardless of haz; a taken branch
  // always suppresses the stall.
  assign w_stall = !branch_taken_E &&
                   (((r_state == S_IDLE) && w_haz) || (r_state == S_STALL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bub_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_haz && !branch_taken_E && (LOAD_STALL_CYCLES > 1)) begin
            r_state   <= S_STALL;
            r_bub_cnt <= LP_EXTRA_BUB;
          end
        end
        S_STALL: begin
          if (branch_taken_E || (r_bub_cnt <= 4'd1)) begin
            r_state   <= S_IDLE;
            r_bub_cnt <= '0;
          end else begin
            r_bub_cnt <= r_bub_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bub_cnt <= '0;
        end
      endcase
    end
  end

  // Clear beats increment; saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Forwarding: M has priority over W, and x0 is never forwarded.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (reg_write_M && (rd_M != '0) && (rd_M == rs1_addr_E)) begin
      w_fwd_a = 2'b10;
    end else if (reg_write_W && (rd_W != '0) && (rd_W == rs1_addr_E)) begin
      w_fwd_a = 2'b01;
    end
    if (reg_write_M && (rd_M != '0) && (rd_M == rs2_addr_E)) begin
      w_fwd_b = 2'b10;
    end else if (reg_write_W && (rd_W != '0) && (rd_W == rs2_addr_E)) begin
      w_fwd_b = 2'b01;
    end
  end

  // Control outputs are combinational (the first bubble must appear in the
  // hazard cycle itself) and are forced low while reset is asserted.
  assign stallF       = rst_n & w_stall;
  assign stallD       = rst_n & w_stall;
  assign flushD       = rst_n & branch_taken_E;
  assign flushE       = rst_n & (w_stall | branch_taken_E);
  assign fwd_a_E      = rst_n ? w_fwd_a : 2'b00;
  assign fwd_b_E      = rst_n ? w_fwd_b : 2'b00;
  assign stall_cycles = r_stall_cnt;
  assign dbg_state    = r_state;

endmodule
